a2d_rr_sched: RTL



---
 rtl/a2d_pkg.sv | 25 ++
 rtl/a2d_rr_sched_if.sv | 10 +
 rtl/a2d_rr_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D round-robin scheduler.
// With A2D_OVRSMP_EN defined, the state set gains READ2 for the second readback.
package a2d_pkg;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  // Element i is the A2D channel serviced at round-robin index i.
  localparam logic [3:0][2:0] CH_ORDER = {CH_BATT, CH_STEER, CH_RGHT, CH_LFT};

  typedef logic [1:0] ch_idx_t;

`ifdef A2D_OVRSMP_EN
  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, READ2} state_e;
`else
  typedef enum logic [2:0] {IDLE, CMD, GAP, READ} state_e;
`endif

  function automatic logic [15:0] cmd_word(input ch_idx_t idx);
    return {2'b00, CH_ORDER[idx], 11'h000};
  endfunction

endpackage

// File: rtl/a2d_rr_sched_if.sv
// Handshake between the scheduler (master) and the external SPI monarch (slave).
interface a2d_rr_sched_if;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output snd, output cmd, input done, input resp);
  modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler: select command, gap, readback, store per channel.
// Optional macro A2D_OVRSMP_EN: two readbacks per conversion, stored result is their rounded mean.
module a2d_rr_sched
  import a2d_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  nxt,
  a2d_rr_sched_if.master        spi,
  output logic [11:0]           lft_ld,
  output logic [11:0]           rght_ld,
  output logic [11:0]           steer_pot,
  output logic [11:0]           batt,
  output logic                  busy,
  output logic                  rdy
);

  state_e      state_q, state_d;
  ch_idx_t     idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        snd_q, snd_d;
  logic        rdy_q, rdy_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] res_q [4];
  logic [11:0] res_d [4];
  logic [11:0] result;
  logic        unused_resp_hi;

  assign unused_resp_hi = ^spi.resp[15:12];

`ifdef A2D_OVRSMP_EN
  logic [11:0] rda_q, rda_d;
  logic        second_q, second_d;
  logic [12:0] sum;

  assign sum    = {1'b0, rda_q} + {1'b0, spi.resp[11:0]} + 13'd1;
  assign result = sum[12:1];
`else
  assign result = spi.resp[11:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      snd_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      for (int i = 0; i < 4; i++) res_q[i] <= 12'h000;
`ifdef A2D_OVRSMP_EN
      rda_q    <= 12'h000;
      second_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      snd_q   <= snd_d;
      rdy_q   <= rdy_d;
      cmd_q   <= cmd_d;
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
`ifdef A2D_OVRSMP_EN
      rda_q    <= rda_d;
      second_q <= second_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    snd_d   = 1'b0;
    rdy_d   = 1'b0;
    cmd_d   = cmd_q;
    for (int i = 0; i < 4; i++) res_d[i] = res_q[i];
`ifdef A2D_OVRSMP_EN
    rda_d    = rda_q;
    second_d = second_q;
`endif

    // Any request outside IDLE, including one coincident with the final done, waits in pending.
    if (nxt && (state_q != IDLE)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (nxt || pend_q) begin
          snd_d   = 1'b1;
          cmd_d   = cmd_word(idx_q);
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CMD;
`ifdef A2D_OVRSMP_EN
          second_d = 1'b0;
`endif
        end
      end
      // The readback snd is launched on the done edge; the GAP cycle carries it while SS_n recovers.
      CMD: begin
        if (spi.done) begin
          snd_d   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
`ifdef A2D_OVRSMP_EN
        state_d = second_q ? READ2 : READ;
`else
        state_d = READ;
`endif
      end
      READ: begin
        if (spi.done) begin
`ifdef A2D_OVRSMP_EN
          rda_d    = spi.resp[11:0];
          second_d = 1'b1;
          snd_d    = 1'b1;
          state_d  = GAP;
`else
          res_d[idx_q] = result;
          rdy_d        = 1'b1;
          idx_d        = idx_q + 2'd1;
          busy_d       = 1'b0;
          state_d      = IDLE;
`endif
        end
      end
`ifdef A2D_OVRSMP_EN
      READ2: begin
        if (spi.done) begin
          res_d[idx_q] = result;
          rdy_d        = 1'b1;
          idx_d        = idx_q + 2'd1;
          busy_d       = 1'b0;
          second_d     = 1'b0;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign spi.snd   = snd_q;
  assign spi.cmd   = cmd_q;
  assign busy      = busy_q;
  assign rdy       = rdy_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule
